adc_sample_sequencer: RTL

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

---
 rtl/adc_sample_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/adc_sample_sequencer.sv
// Periodic ADC conversion sequencer: drives convst_bar, captures adc_data,
// keeps a 4-sample running mean and a sticky out-of-window fault.
module adc_sample_sequencer #(
    parameter int PERIOD   = 500,
    parameter int PULSE_W  = 4,
    parameter int CONV_CYC = 20,
    parameter int FAULT_N  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] adc_data,
    input  logic [7:0] hi_th,
    input  logic [7:0] lo_th,
    input  logic       clr_fault,
    output logic       convst_bar,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic [7:0] sample_avg,
    output logic       fault
);

    localparam int PCW  = $clog2(PERIOD);
    localparam int CMAX = (PULSE_W > CONV_CYC) ? PULSE_W : CONV_CYC;
    localparam int CCW  = $clog2(CMAX);
    localparam logic [PCW-1:0] P_LAST     = PCW'(PERIOD - 1);
    localparam logic [CCW-1:0] PULSE_LAST = CCW'(PULSE_W - 1);
    localparam logic [CCW-1:0] CONV_LAST  = CCW'(CONV_CYC - 1);
    localparam logic [2:0]     FAULT_LIM  = 3'(FAULT_N);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONV    = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    function automatic logic out_of_window(input logic [7:0] d, input logic [7:0] hi,
                                           input logic [7:0] lo);
        return (d > hi) || (d < lo);
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    state_t           state_r;
    logic [PCW-1:0]   pcnt_r;
    logic [CCW-1:0]   ccnt_r;
    logic             convst_bar_r;
    logic             sample_valid_r;
    logic [7:0]       sample_r;
    logic [7:0]       sample_avg_r;
    logic [3:0][7:0]  hist_r;
    logic [9:0]       sum_r;
    logic [1:0]       out_cnt_r;
    logic             fault_r;

    logic             capture_s;
    logic             pwrap_s;
    logic [1:0]       next_cnt_s;
    logic             fault_set_s;
    logic [9:0]       sum_next_s;

    // Capture decision, window update and running-sum next values
    always_comb begin
        capture_s   = (state_r == WAIT) && (ccnt_r == CONV_LAST);
        pwrap_s     = (pcnt_r == P_LAST);
        next_cnt_s  = out_of_window(adc_data, hi_th, lo_th) ? sat_inc2(out_cnt_r) : 2'd0;
        fault_set_s = capture_s && ({1'b0, next_cnt_s} >= FAULT_LIM);
        sum_next_s  = sum_r + {2'b00, adc_data} - {2'b00, hist_r[3]};
    end

    // Conversion FSM with period counter and registered strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= IDLE;
            convst_bar_r   <= 1'b1;
            sample_valid_r <= 1'b0;
            ccnt_r         <= '0;
            pcnt_r         <= '0;
        end else begin
            sample_valid_r <= 1'b0;
            if (state_r != IDLE) begin
                pcnt_r <= pwrap_s ? '0 : pcnt_r + 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (en) begin
                        state_r      <= CONV;
                        convst_bar_r <= 1'b0;
                        ccnt_r       <= '0;
                        pcnt_r       <= '0;
                    end
                end
                CONV: begin
                    if (ccnt_r == PULSE_LAST) begin
                        state_r      <= WAIT;
                        convst_bar_r <= 1'b1;
                        ccnt_r       <= '0;
                    end else begin
                        ccnt_r <= ccnt_r + 1'b1;
                    end
                end
                WAIT: begin
                    if (capture_s) begin
                        state_r        <= CAPTURE;
                        sample_valid_r <= 1'b1;
                        ccnt_r         <= '0;
                    end else begin
                        ccnt_r <= ccnt_r + 1'b1;
                    end
                end
                CAPTURE: begin
                    state_r <= HOLD;
                end
                HOLD: begin
                    // en is only consulted at the period boundary
                    if (pwrap_s) begin
                        pcnt_r <= '0;
                        ccnt_r <= '0;
                        if (en) begin
                            state_r      <= CONV;
                            convst_bar_r <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    convst_bar_r <= 1'b1;
                    ccnt_r       <= '0;
                    pcnt_r       <= '0;
                end
            endcase
        end
    end

    // Sample capture, averaging history, out-of-window count and sticky fault
    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_r     <= 8'd0;
            sample_avg_r <= 8'd0;
            hist_r       <= '0;
            sum_r        <= 10'd0;
            out_cnt_r    <= 2'd0;
            fault_r      <= 1'b0;
        end else begin
            if (capture_s) begin
                sample_r     <= adc_data;
                hist_r       <= {hist_r[2:0], adc_data};
                sum_r        <= sum_next_s;
                sample_avg_r <= sum_next_s[9:2];
                out_cnt_r    <= next_cnt_s;
            end else if (clr_fault) begin
                out_cnt_r <= 2'd0;
            end
            // A setting capture takes priority over a coincident clear
            if (fault_set_s) begin
                fault_r <= 1'b1;
            end else if (clr_fault) begin
                fault_r <= 1'b0;
            end
        end
    end

    assign convst_bar   = convst_bar_r;
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign sample_avg   = sample_avg_r;
    assign fault        = fault_r;

endmodule
